// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - execute, memory-controller and write-back signals of the memory stage.
// The stage is the slave; the execute side, memory controller and register file are the master.
interface mem_access_stage_if #(
  parameter int ADDR_W = 32
);
  logic              valid_i;
  logic              ready_o;
  logic              is_load_i;
  logic              is_store_i;
  logic [2:0]        funct3_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       sdata_i;
  logic [31:0]       alu_i;
  logic              wreg_i;
  logic [4:0]        rd_i;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_dout_o;
  logic [7:0]        mem_din_i;
  logic              mem_ack_i;
  logic              wb_valid_o;
  logic              we_o;
  logic [4:0]        waddr_o;
  logic [31:0]       wdata_o;
  logic              misalign_o;

  modport slave (
    input  valid_i, is_load_i, is_store_i, funct3_i, addr_i, sdata_i, alu_i,
           wreg_i, rd_i, mem_din_i, mem_ack_i,
    output ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_dout_o,
           wb_valid_o, we_o, waddr_o, wdata_o, misalign_o
  );

  modport master (
    output valid_i, is_load_i, is_store_i, funct3_i, addr_i, sdata_i, alu_i,
           wreg_i, rd_i, mem_din_i, mem_ack_i,
    input  ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_dout_o,
           wb_valid_o, we_o, waddr_o, wdata_o, misalign_o
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - byte-serial load/store stage feeding the register file write port.
// Optional MEM_ALIGN_CHECK_EN: misaligned H/W accesses retire with misalign_o instead of accessing memory.
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_stage_if.slave bus
);
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic [4:0]        rd_q;
  logic              wreg_q;
  logic              load_q;
  logic              store_q;
  logic [1:0]        k_q;
  logic [1:0]        last_k;
  logic [31:0]       asm_q;
  logic [31:0]       load_word;
  logic [31:0]       load_ext;

  logic              wb_valid_q;
  logic              we_q;
  logic [4:0]        waddr_q;
  logic [31:0]       wdata_q;
  logic              misalign_q;

  logic accept;
  logic is_mem;
  logic misaligned;
  logic ack_last;

  assign accept = bus.valid_i && (state_q == IDLE);
  assign is_mem = bus.is_load_i || bus.is_store_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_mem &&
                      (((bus.funct3_i[1:0] == 2'b01) && bus.addr_i[0]) ||
                       (bus.funct3_i[1] && (bus.addr_i[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    last_k = 2'd3;
    case (f3_q[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  assign ack_last = (state_q == ACCESS) && bus.mem_ack_i && (k_q == last_k);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && is_mem && !misaligned) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (ack_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The final byte is merged straight from mem_din_i so the result retires on its ack edge.
  always_comb begin
    load_word = asm_q;
    load_word[{k_q, 3'b000} +: 8] = bus.mem_din_i;
  end

  always_comb begin
    load_ext = load_word;
    case (f3_q)
      3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
      3'b100:  load_ext = {24'd0, load_word[7:0]};
      3'b101:  load_ext = {16'd0, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f3_q       <= 3'd0;
      addr_q     <= '0;
      sdata_q    <= 32'd0;
      rd_q       <= 5'd0;
      wreg_q     <= 1'b0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      k_q        <= 2'd0;
      asm_q      <= 32'd0;
      wb_valid_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= 5'd0;
      wdata_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;

      if (accept) begin
        f3_q    <= bus.funct3_i;
        addr_q  <= bus.addr_i;
        sdata_q <= bus.sdata_i;
        rd_q    <= bus.rd_i;
        wreg_q  <= bus.wreg_i;
        load_q  <= bus.is_load_i;
        store_q <= bus.is_store_i;
        k_q     <= 2'd0;
        if (!is_mem) begin
          wb_valid_q <= 1'b1;
          we_q       <= bus.wreg_i && (bus.rd_i != 5'd0);
          waddr_q    <= bus.rd_i;
          wdata_q    <= bus.alu_i;
        end else if (misaligned) begin
          wb_valid_q <= 1'b1;
          misalign_q <= 1'b1;
          waddr_q    <= bus.rd_i;
          wdata_q    <= 32'd0;
        end
      end

      if ((state_q == ACCESS) && bus.mem_ack_i) begin
        if (load_q) begin
          asm_q[{k_q, 3'b000} +: 8] <= bus.mem_din_i;
        end
        k_q <= k_q + 2'd1;
        if (k_q == last_k) begin
          wb_valid_q <= 1'b1;
          waddr_q    <= rd_q;
          if (load_q) begin
            we_q    <= wreg_q && (rd_q != 5'd0);
            wdata_q <= load_ext;
          end else begin
            wdata_q <= 32'd0;
          end
        end
      end
    end
  end

  // Memory-side outputs are decoded from state so a reset drops the request at once.
  assign bus.ready_o    = (state_q == IDLE);
  assign bus.mem_req_o  = (state_q == ACCESS);
  assign bus.mem_we_o   = (state_q == ACCESS) && store_q;
  assign bus.mem_addr_o = (state_q == ACCESS) ? (addr_q + ADDR_W'(k_q)) : '0;
  assign bus.mem_dout_o = (state_q == ACCESS) ? sdata_q[{k_q, 3'b000} +: 8] : 8'd0;

  assign bus.wb_valid_o = wb_valid_q;
  assign bus.we_o       = we_q;
  assign bus.waddr_o    = waddr_q;
  assign bus.wdata_o    = wdata_q;
  assign bus.misalign_o = misalign_q;
endmodule
